// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the fetch stage.
//   DEF_RESET_PC  - default PC after reset
//   DEF_NOP_INSTR - default instruction word shown in D when d_valid=0
//   fetch_state_e - fetch control FSM encoding
//   FD_W          - width of the F/D {pc, instr} bundle
//   fd_bundle_t   - F/D pipeline register payload
package ifu_fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam int          FD_W          = 64;

  typedef enum logic {
    FETCH = 1'b0,  // request outstanding, waiting for ack
    HOLD  = 1'b1   // word received while D stalled, parked in hold_buf
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_bundle_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory read handshake.
//   req   - read request (fetch -> memory)
//   addr  - word-aligned read address (fetch -> memory)
//   ack   - read data valid this cycle, may be same cycle as req (memory -> fetch)
//   rdata - instruction word, valid with ack (memory -> fetch)
// master = fetch stage, slave = instruction memory.
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifu_fetch_fd_reg.sv
// ifu_fetch_fd_reg: F/D pipeline register.
//   clk, reset - clock and asynchronous active-low reset
//   en         - advance: load d and mark D valid
//   d          - incoming {pc, instr}
//   q          - registered {d_pc, d_instr}
//   valid      - D holds a real instruction; sticky once set
module ifu_fetch_fd_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  fd_bundle_t d,
  output fd_bundle_t q,
  output logic       valid
);

  logic [FD_W-1:0] fd_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fd_q  <= {32'h0, NOP_INSTR};
      valid <= 1'b0;
    end else if (en) begin
      fd_q  <= d;
      valid <= 1'b1;
    end
  end

  assign q = fd_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: F stage of the 5-stage MIPS pipeline.
//   clk, reset - clock and asynchronous active-low reset
//   npc        - next PC from next-PC block, sampled only when F/D advances
//   stall_d    - hazard-unit stall of F/D (excludes fetch_busy)
//   imem       - instruction-memory handshake (master side)
//   f_pc       - current fetch PC, also drives imem.addr
//   d_pc, d_instr, d_valid - F/D register contents
//   fetch_busy - fetch outstanding and not acked this cycle
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         npc,
  input  logic                stall_d,
  ifu_fetch_if.master         imem,
  output logic [31:0]         f_pc,
  output logic [31:0]         d_pc,
  output logic [31:0]         d_instr,
  output logic                d_valid,
  output logic                fetch_busy
);

  fetch_state_e state, state_nxt;
  logic [31:0]  hold_buf;
  logic [31:0]  npc_aligned;
  logic         deliver;   // a word for f_pc is available this cycle
  logic         advance;   // F/D loads and f_pc moves to npc
  logic         park;      // word arrives while D stalled
  fd_bundle_t   fd_d, fd_q;

  // Low two bits of npc are dropped so f_pc stays word aligned.
  assign npc_aligned = npc & ~32'h3;

  assign deliver = (state == HOLD) || imem.ack;
  assign advance = deliver && !stall_d;
  assign park    = (state == FETCH) && imem.ack && stall_d;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (imem.ack && stall_d) state_nxt = HOLD;
      HOLD:  if (!stall_d)            state_nxt = FETCH;
    endcase
  end

  // Output logic: req is a function of state (and reset) only, so there is
  // no combinational path from stall_d.
  always_comb begin
    imem.req   = 1'b0;
    fetch_busy = 1'b0;
    if (state == FETCH) begin
      imem.req   = reset;
      fetch_busy = !imem.ack;
    end
  end

  assign imem.addr = f_pc;

  // PC register and hold buffer.
  // NOTE: hold_buf is reset along with the control state; it is only read
  // in HOLD, but a defined value keeps reset behaviour fully deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc     <= RESET_PC;
      hold_buf <= '0;
    end else begin
      if (advance) f_pc     <= npc_aligned;
      if (park)    hold_buf <= imem.rdata;
    end
  end

  assign fd_d.pc    = f_pc;
  assign fd_d.instr = (state == HOLD) ? hold_buf : imem.rdata;

  ifu_fetch_fd_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_fd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (advance),
    .d     (fd_d),
    .q     (fd_q),
    .valid (d_valid)
  );

  assign d_pc    = fd_q.pc;
  assign d_instr = fd_q.instr;

  // An ack without an outstanding request (including in HOLD) is a memory
  // protocol error; the design ignores it.
  ack_without_req : assert property (
    @(posedge clk) disable iff (!reset) !(imem.ack && !imem.req)
  );

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Fetch stage of the 5-stage MIPS pipeline.
- Holds the F-stage PC register, drives the instruction-memory request/ack handshake, and owns the F/D pipeline register.
- Consumes npc from the next-PC block and returns f_pc to it. Supplies d_pc/d_instr to the D stage and to next-PC.
- Supports variable-latency instruction memory, including same-cycle (zero-wait) ack.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word presented in D when d_valid=0.

Ports:
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- npc  in  32  next PC from next-PC block, valid every cycle
- stall_d  in  1  hazard-unit stall of F/D; does NOT include fetch_busy
- imem_req  out  1  instruction read request
- imem_addr  out  32  read address (= f_pc)
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- f_pc  out  32  current fetch PC
- d_pc  out  32  PC of instruction in D
- d_instr  out  32  instruction in D
- d_valid  out  1  D holds a real instruction
- fetch_busy  out  1  fetch not complete; top level ORs this into the D/F stall and inserts an E bubble

Behaviour:
- Reset (reset=0, async):
  - f_pc=RESET_PC, d_pc=0, d_instr=NOP_INSTR, d_valid=0.
  - state=FETCH, hold buffer cleared.
  - imem_req forced 0 while reset=0.
  - Reset mid-request abandons the request; the memory tolerates a dropped req.
  - First request is made in the first cycle after deassertion, with addr=RESET_PC.
- State FETCH:
  - imem_req=1, imem_addr=f_pc; both held stable until ack.
  - ack=1 and stall_d=0: F/D <= {f_pc, imem_rdata}, d_valid<=1, f_pc<={npc[31:2],2'b00}; stay in FETCH. Zero-wait memory gives one instruction per cycle.
  - ack=1 and stall_d=1: hold_buf<=imem_rdata; F/D and f_pc unchanged; go to HOLD.
  - ack=0: F/D, f_pc unchanged; fetch_busy=1 (combinational, = FETCH && !imem_ack).
- State HOLD:
  - imem_req=0, fetch_busy=0.
  - stall_d=1: everything holds.
  - stall_d=0: F/D <= {f_pc, hold_buf}, d_valid<=1, f_pc<={npc[31:2],2'b00}; go to FETCH.
- Invariants:
  - F/D changes only when an instruction for f_pc is delivered and stall_d=0. D is never overwritten by a bubble, so a branch/jump in D keeps driving npc until its delay-slot instruction has been fetched.
  - npc is sampled only on the F/D advance edge.
  - d_valid stays 0 from reset until the first delivered instruction. Thereafter it stays 1 (no flush; delay slots are architectural).
  - npc low two bits are ignored; f_pc is always word aligned.
  - ack while in HOLD, or while req=0, is a protocol error. It is ignored and flagged by a simulation-only assertion.
  - PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no special handling (done in next-PC).
- No combinational path from stall_d to imem_req. fetch_busy depends only on state and imem_ack.

Decomposition:
- Shared pipeline header/package holds:
  - RESET_PC, NOP_INSTR;
  - FSM state encodings FETCH=1'b0, HOLD=1'b1;
  - F/D bundle width constant (64).
- One sub-module, fd_reg: enable-gated, async active-low reset register for {d_pc, d_instr, d_valid}, enabled by the advance condition.
- Control FSM, hold buffer and PC register stay in ifu_fetch.

Test Plan:
- Reset then zero-wait ack every cycle, npc=f_pc+4 -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; d_pc trails by one cycle; d_valid rises the cycle after the first ack.
- Ack latency 3 cycles at 0x3004 -> imem_req/addr stable for 3 cycles; fetch_busy=1 for 2 cycles; d_pc stays 0x3000 until the ack edge.
- Ack with stall_d=1 for 2 cycles, rdata=0x1234_5678 -> state HOLD, imem_req=0; after stall drops, d_instr=0x1234_5678 with correct d_pc; fetch resumes at npc.
- beq in D with npc target 0x3100, delay-slot fetch ack delayed 2 cycles -> D holds the beq until the delay slot is delivered; the next fetch address is 0x3100.
- Assert reset low mid-request at addr 0x3040 -> outputs reach reset values immediately (async); after release, the first req is at 0x3000.
- npc=0x0000_3013 -> f_pc loads 0x0000_3010.
